// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: wraps bytes in 01111110 flags, stuffs a zero after five data ones,
// and aborts with seven ones when the byte stream starves mid-frame.
module hdlc_tx_framer #(
  parameter int FLAG_GAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       tx_bit,
  output logic       tx_active,
  output logic       tx_abort
);

  localparam int FW = (FLAG_GAP > 1) ? $clog2(FLAG_GAP) : 1;
  localparam logic [7:0] FLAG = 8'h7E;

  typedef enum logic [2:0] {IDLE, OPEN, DATA, STUFF, CLOSE, ABORT} state_t;

  state_t        state, state_nx;
  logic [7:0]    hold, hold_nx, shift, shift_nx;
  logic          hold_last, hold_last_nx, hold_full, hold_full_nx;
  logic          shift_last, shift_last_nx;
  logic [2:0]    bit_idx, bit_idx_nx, ones_cnt, ones_cnt_nx;
  logic [FW-1:0] flag_cnt, flag_cnt_nx;
  logic          out_bit, out_active, out_abort, byte_done, accept;

  // Ready only between frames (once the line has gone idle) or while a non-final byte is on the wire.
  always_comb begin
    data_ready = 1'b0;
    if (reset && !hold_full) begin
      case (state)
        IDLE:        data_ready = !tx_active;
        DATA, STUFF: data_ready = !shift_last;
        default:     data_ready = 1'b0;
      endcase
    end
  end

  assign accept = data_valid && data_ready;

  always_comb begin
    state_nx      = state;
    hold_nx       = hold;
    hold_last_nx  = hold_last;
    hold_full_nx  = hold_full;
    shift_nx      = shift;
    shift_last_nx = shift_last;
    bit_idx_nx    = bit_idx;
    ones_cnt_nx   = ones_cnt;
    flag_cnt_nx   = flag_cnt;
    out_bit       = 1'b1;
    out_active    = 1'b0;
    out_abort     = 1'b0;
    byte_done     = 1'b0;

    if (accept) begin
      hold_nx      = data;
      hold_last_nx = data_last;
      hold_full_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          state_nx   = OPEN;
          bit_idx_nx = 3'd0;
        end
      end
      OPEN: begin
        out_bit    = FLAG[bit_idx];
        out_active = 1'b1;
        bit_idx_nx = bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
          shift_nx      = hold;
          shift_last_nx = hold_last;
          hold_full_nx  = 1'b0;
          ones_cnt_nx   = 3'd0;
          state_nx      = DATA;
        end
      end
      DATA: begin
        out_bit     = shift[bit_idx];
        out_active  = 1'b1;
        ones_cnt_nx = shift[bit_idx] ? ones_cnt + 3'd1 : 3'd0;
        // The stuff bit is inserted before the index advances, so it may trail bit 7.
        if (shift[bit_idx] && ones_cnt == 3'd4) state_nx = STUFF;
        else if (bit_idx == 3'd7)               byte_done = 1'b1;
        else                                    bit_idx_nx = bit_idx + 3'd1;
      end
      STUFF: begin
        out_bit     = 1'b0;
        out_active  = 1'b1;
        ones_cnt_nx = 3'd0;
        if (bit_idx == 3'd7) byte_done = 1'b1;
        else begin
          bit_idx_nx = bit_idx + 3'd1;
          state_nx   = DATA;
        end
      end
      CLOSE: begin
        out_bit    = FLAG[bit_idx];
        out_active = 1'b1;
        bit_idx_nx = bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
          if (flag_cnt == FW'(FLAG_GAP - 1)) state_nx = IDLE;
          else                               flag_cnt_nx = flag_cnt + 1'b1;
        end
      end
      ABORT: begin
        out_bit    = 1'b1;
        out_active = 1'b1;
        out_abort  = (bit_idx == 3'd0);
        if (bit_idx == 3'd6) begin
          bit_idx_nx = 3'd0;
          state_nx   = IDLE;
        end else begin
          bit_idx_nx = bit_idx + 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A byte accepted on the very edge that ends the current byte goes straight into shift.
    if (byte_done) begin
      bit_idx_nx = 3'd0;
      if (shift_last) begin
        state_nx    = CLOSE;
        flag_cnt_nx = '0;
      end else if (hold_full) begin
        shift_nx      = hold;
        shift_last_nx = hold_last;
        hold_full_nx  = 1'b0;
        state_nx      = DATA;
      end else if (accept) begin
        shift_nx      = data;
        shift_last_nx = data_last;
        hold_full_nx  = 1'b0;
        state_nx      = DATA;
      end else begin
        state_nx = ABORT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      hold       <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      shift      <= '0;
      shift_last <= 1'b0;
      bit_idx    <= '0;
      ones_cnt   <= '0;
      flag_cnt   <= '0;
      tx_bit     <= 1'b1;
      tx_active  <= 1'b0;
      tx_abort   <= 1'b0;
    end else begin
      state      <= state_nx;
      hold       <= hold_nx;
      hold_last  <= hold_last_nx;
      hold_full  <= hold_full_nx;
      shift      <= shift_nx;
      shift_last <= shift_last_nx;
      bit_idx    <= bit_idx_nx;
      ones_cnt   <= ones_cnt_nx;
      flag_cnt   <= flag_cnt_nx;
      tx_bit     <= out_bit;
      tx_active  <= out_active;
      tx_abort   <= out_abort;
    end
  end

endmodule
